// File: rtl/mem_ddr_rw_arbiter_pkg.sv
// Shared definitions for the DDR read/write burst arbiter: state encoding,
// field widths and the write-streak counter helper.
package mem_ddr_rw_arbiter_pkg;

  localparam int DDR_LEN_W   = 8;
  localparam int BURST_CNT_W = 32;
  localparam int CONSEC_W    = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WR   = 2'd1,
    ARB_RD   = 2'd2,
    ARB_GAP  = 2'd3
  } arb_state_e;

  function automatic logic [CONSEC_W-1:0] sat_inc(input logic [CONSEC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Per-burst watchdog: saturating cycle counter with a sticky flag that rises
// on the same edge the counter reaches all-ones.
module mem_arb_watchdog #(
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (en && !(&cnt))
        cnt <= cnt + 1'b1;
      // upper bits all-ones means the count is at max-1 or max: this edge lands on all-ones
      if (en && !clr && (&cnt[CNT_W-1:1]))
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_ddr_rw_arbiter.sv
// Arbitrates the single DDR burst port between the write path and the vout
// read path, one whole burst at a time, with a write-streak cap.
module mem_ddr_rw_arbiter
  import mem_ddr_rw_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 30,
  parameter int MEM_DATA_BITS = 256,
  parameter int WR_MAX_CONSEC = 4,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_n_i,
  input  logic                     wr_ddr_req_i,
  input  logic [DDR_LEN_W-1:0]     wr_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]    wr_ddr_addr_i,
  input  logic [MEM_DATA_BITS-1:0] wr_ddr_data_i,
  output logic                     wr_ddr_data_req_o,
  output logic                     wr_ddr_finish_o,
  input  logic                     rd_ddr_req_i,
  input  logic [DDR_LEN_W-1:0]     rd_ddr_len_i,
  input  logic [ADDR_WIDTH-1:0]    rd_ddr_addr_i,
  output logic                     rd_ddr_data_valid_o,
  output logic [MEM_DATA_BITS-1:0] rd_ddr_data_o,
  output logic                     rd_ddr_finish_o,
  output logic                     mem_wr_req_o,
  output logic                     mem_rd_req_o,
  output logic [DDR_LEN_W-1:0]     mem_len_o,
  output logic [ADDR_WIDTH-1:0]    mem_addr_o,
  input  logic                     mem_wr_data_req_i,
  input  logic                     mem_wr_finish_i,
  output logic [MEM_DATA_BITS-1:0] mem_wr_data_o,
  input  logic                     mem_rd_data_valid_i,
  input  logic                     mem_rd_finish_i,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_data_i,
  output logic [BURST_CNT_W-1:0]   wr_burst_cnt_o,
  output logic [BURST_CNT_W-1:0]   rd_burst_cnt_o,
  output logic                     timeout_err_o,
  output logic                     spurious_err_o
);

  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(WR_MAX_CONSEC);

  typedef struct packed {
    logic [DDR_LEN_W-1:0]  len;
    logic [ADDR_WIDTH-1:0] addr;
  } burst_t;

  arb_state_e          state, state_nxt;
  burst_t              cmd;
  logic [CONSEC_W-1:0] wr_consec;
  logic                wr_grant, rd_grant;
  logic                wr_busy, rd_busy;
  logic                spur_hit;

  assign wr_busy = (state == ARB_WR);
  assign rd_busy = (state == ARB_RD);

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) state <= ARB_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    case (state)
      ARB_IDLE: begin
        // a pending read only loses to a write while the write streak is under the cap
        if (wr_ddr_req_i && (!rd_ddr_req_i || wr_consec < CONSEC_MAX)) begin
          state_nxt = ARB_WR;
          wr_grant  = 1'b1;
        end else if (rd_ddr_req_i) begin
          state_nxt = ARB_RD;
          rd_grant  = 1'b1;
        end
      end
      ARB_WR:  if (mem_wr_finish_i) state_nxt = ARB_GAP;
      ARB_RD:  if (mem_rd_finish_i) state_nxt = ARB_GAP;
      ARB_GAP: state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      mem_wr_req_o <= 1'b0;
      mem_rd_req_o <= 1'b0;
      cmd          <= '0;
    end else begin
      if (wr_grant) begin
        mem_wr_req_o <= 1'b1;
        cmd          <= '{len: wr_ddr_len_i, addr: wr_ddr_addr_i};
      end else if (wr_busy && (mem_wr_data_req_i || mem_wr_finish_i)) begin
        mem_wr_req_o <= 1'b0;
      end
      if (rd_grant) begin
        mem_rd_req_o <= 1'b1;
        cmd          <= '{len: rd_ddr_len_i, addr: rd_ddr_addr_i};
      end else if (rd_busy && (mem_rd_data_valid_i || mem_rd_finish_i)) begin
        mem_rd_req_o <= 1'b0;
      end
    end
  end

  assign mem_len_o  = cmd.len;
  assign mem_addr_o = cmd.addr;

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i)
      wr_consec <= '0;
    else if (state == ARB_IDLE) begin
      if (!rd_ddr_req_i || rd_grant) wr_consec <= '0;
      else if (wr_grant)             wr_consec <= sat_inc(wr_consec);
    end
  end

  assign wr_ddr_data_req_o   = wr_busy & mem_wr_data_req_i;
  assign wr_ddr_finish_o     = wr_busy & mem_wr_finish_i;
  assign rd_ddr_data_valid_o = rd_busy & mem_rd_data_valid_i;
  assign rd_ddr_finish_o     = rd_busy & mem_rd_finish_i;
  assign rd_ddr_data_o       = mem_rd_data_i;
  assign mem_wr_data_o       = wr_ddr_data_i;

  assign spur_hit = ((mem_wr_data_req_i | mem_wr_finish_i) & ~wr_busy) |
                    ((mem_rd_data_valid_i | mem_rd_finish_i) & ~rd_busy);

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      wr_burst_cnt_o <= '0;
      rd_burst_cnt_o <= '0;
      spurious_err_o <= 1'b0;
    end else begin
      if (wr_ddr_finish_o) wr_burst_cnt_o <= wr_burst_cnt_o + 1'b1;
      if (rd_ddr_finish_o) rd_burst_cnt_o <= rd_burst_cnt_o + 1'b1;
      if (spur_hit)        spurious_err_o <= 1'b1;
    end
  end

  mem_arb_watchdog #(
    .CNT_W (TIMEOUT_BITS)
  ) u_watchdog (
    .clk     (ddr_clk_i),
    .rst_n   (ddr_rst_n_i),
    .clr     (~(wr_busy | rd_busy)),
    .en      (wr_busy | rd_busy),
    .timeout (timeout_err_o)
  );

endmodule

// File: tb/tb_mem_ddr_rw_arbiter.sv
// Randomized bench for mem_ddr_rw_arbiter: a burst-level ownership model
// predicts every output each cycle; directed scenarios cover the corner cases.
module tb_mem_ddr_rw_arbiter;

  localparam int AW = 30;
  localparam int DW = 256;
  localparam int WDMAX = 255;   // all-ones of an 8-bit watchdog
  localparam int O_IDLE = 0, O_WR = 1, O_RD = 2, O_GAP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_ddr_req_i = 0, rd_ddr_req_i = 0;
  logic [7:0]    wr_ddr_len_i = 0, rd_ddr_len_i = 0;
  logic [AW-1:0] wr_ddr_addr_i = 0, rd_ddr_addr_i = 0;
  logic [DW-1:0] wr_ddr_data_i = 0, mem_rd_data_i = 0;
  logic          mem_wr_data_req_i = 0, mem_wr_finish_i = 0;
  logic          mem_rd_data_valid_i = 0, mem_rd_finish_i = 0;
  logic          wr_ddr_data_req_o, wr_ddr_finish_o, rd_ddr_data_valid_o, rd_ddr_finish_o;
  logic [DW-1:0] rd_ddr_data_o, mem_wr_data_o;
  logic          mem_wr_req_o, mem_rd_req_o;
  logic [7:0]    mem_len_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   wr_burst_cnt_o, rd_burst_cnt_o;
  logic          timeout_err_o, spurious_err_o;

  always #5 clk = ~clk;

  mem_ddr_rw_arbiter #(
    .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .WR_MAX_CONSEC(4), .TIMEOUT_BITS(8)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_n_i(rst_n),
    .wr_ddr_req_i(wr_ddr_req_i), .wr_ddr_len_i(wr_ddr_len_i), .wr_ddr_addr_i(wr_ddr_addr_i),
    .wr_ddr_data_i(wr_ddr_data_i), .wr_ddr_data_req_o(wr_ddr_data_req_o), .wr_ddr_finish_o(wr_ddr_finish_o),
    .rd_ddr_req_i(rd_ddr_req_i), .rd_ddr_len_i(rd_ddr_len_i), .rd_ddr_addr_i(rd_ddr_addr_i),
    .rd_ddr_data_valid_o(rd_ddr_data_valid_o), .rd_ddr_data_o(rd_ddr_data_o), .rd_ddr_finish_o(rd_ddr_finish_o),
    .mem_wr_req_o(mem_wr_req_o), .mem_rd_req_o(mem_rd_req_o), .mem_len_o(mem_len_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_req_i(mem_wr_data_req_i), .mem_wr_finish_i(mem_wr_finish_i), .mem_wr_data_o(mem_wr_data_o),
    .mem_rd_data_valid_i(mem_rd_data_valid_i), .mem_rd_finish_i(mem_rd_finish_i), .mem_rd_data_i(mem_rd_data_i),
    .wr_burst_cnt_o(wr_burst_cnt_o), .rd_burst_cnt_o(rd_burst_cnt_o),
    .timeout_err_o(timeout_err_o), .spurious_err_o(spurious_err_o)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // burst-level model: who owns the port, what was issued, what has completed
  int            owner, consec, wdc, beats;
  logic          m_wr_req, m_rd_req, m_tout, m_spur;
  logic [7:0]    m_len;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wcnt, m_rcnt;
  logic          wr_done, rd_done;
  logic          pw, pr;
  logic [15:0]   glog;
  int            gn, rd_fwd;
  int unsigned   strobe_pct, fin_pct, spur_pct;

  task automatic model_reset();
    owner = O_IDLE; consec = 0; wdc = 0; beats = 0;
    m_wr_req = 0; m_rd_req = 0; m_tout = 0; m_spur = 0;
    m_len = 0; m_addr = 0; m_wcnt = 0; m_rcnt = 0;
    wr_done = 0; rd_done = 0; pw = 0; pr = 0;
  endtask

  task automatic check_outputs();
    chk("mem_req", DW'({mem_wr_req_o, mem_rd_req_o}), DW'({m_wr_req, m_rd_req}));
    chk("mem_cmd", DW'({mem_len_o, mem_addr_o}), DW'({m_len, m_addr}));
    chk("steer", DW'({wr_ddr_data_req_o, wr_ddr_finish_o, rd_ddr_data_valid_o, rd_ddr_finish_o}),
        DW'({owner == O_WR && mem_wr_data_req_i, owner == O_WR && mem_wr_finish_i,
             owner == O_RD && mem_rd_data_valid_i, owner == O_RD && mem_rd_finish_i}));
    chk("burst_cnt", DW'({wr_burst_cnt_o, rd_burst_cnt_o}), DW'({m_wcnt, m_rcnt}));
    chk("err_flags", DW'({timeout_err_o, spurious_err_o}), DW'({m_tout, m_spur}));
    chk("wr_data", mem_wr_data_o, wr_ddr_data_i);
    chk("rd_data", rd_ddr_data_o, mem_rd_data_i);
    if (mem_wr_req_o && !pw) begin glog = {glog[14:0], 1'b1}; gn++; end
    if (mem_rd_req_o && !pr) begin glog = {glog[14:0], 1'b0}; gn++; end
    pw = mem_wr_req_o; pr = mem_rd_req_o;
    if (rd_ddr_data_valid_o) rd_fwd++;
  endtask

  task automatic model_adv();
    int  old;
    bit  gw, gr;
    old = owner;
    if (((mem_wr_data_req_i || mem_wr_finish_i) && old != O_WR) ||
        ((mem_rd_data_valid_i || mem_rd_finish_i) && old != O_RD)) m_spur = 1;
    if (old == O_WR || old == O_RD) begin
      if (wdc < WDMAX) wdc++;
      if (wdc == WDMAX) m_tout = 1;
    end
    case (old)
      O_WR: begin
        if (mem_wr_data_req_i || mem_wr_finish_i) m_wr_req = 0;
        if (mem_wr_finish_i) begin m_wcnt++; owner = O_GAP; wdc = 0; wr_done = 1; end
      end
      O_RD: begin
        if (mem_rd_data_valid_i || mem_rd_finish_i) m_rd_req = 0;
        if (mem_rd_finish_i) begin m_rcnt++; owner = O_GAP; wdc = 0; rd_done = 1; end
      end
      O_GAP: owner = O_IDLE;
      default: begin
        gw = wr_ddr_req_i && (!rd_ddr_req_i || consec < 4);
        gr = rd_ddr_req_i && !gw;
        if (!rd_ddr_req_i || gr) consec = 0;
        else if (gw && consec < 15) consec++;
        if (gw) begin owner = O_WR; m_wr_req = 1; m_len = wr_ddr_len_i; m_addr = wr_ddr_addr_i; beats = wr_ddr_len_i; end
        if (gr) begin owner = O_RD; m_rd_req = 1; m_len = rd_ddr_len_i; m_addr = rd_ddr_addr_i; beats = rd_ddr_len_i; end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (!rst_n) model_reset();
    else        model_adv();
    @(posedge clk);
    #1;
  endtask

  // memory controller stand-in: serves the owner's burst, optionally injects stray strobes
  task automatic drive_mem();
    int d;
    mem_wr_data_req_i = 0; mem_wr_finish_i = 0; mem_rd_data_valid_i = 0; mem_rd_finish_i = 0;
    for (int k = 0; k < DW / 32; k++) begin
      wr_ddr_data_i[k*32 +: 32] = $urandom;
      mem_rd_data_i[k*32 +: 32] = $urandom;
    end
    if (owner == O_WR || owner == O_RD) begin
      if (beats > 0) begin
        if ($urandom_range(99) < strobe_pct) begin
          beats--;
          if (owner == O_WR) mem_wr_data_req_i = 1; else mem_rd_data_valid_i = 1;
        end
      end else if ($urandom_range(99) < fin_pct) begin
        if (owner == O_WR) mem_wr_finish_i = 1; else mem_rd_finish_i = 1;
      end
    end
    if ($urandom_range(99) < spur_pct) begin
      d = $urandom_range(2, 1);
      if (d != owner) begin
        if (d == O_WR) begin
          if ($urandom_range(1) == 0) mem_wr_data_req_i = 1; else mem_wr_finish_i = 1;
        end else begin
          if ($urandom_range(1) == 0) mem_rd_data_valid_i = 1; else mem_rd_finish_i = 1;
        end
      end
    end
  endtask

  task automatic drive_req();
    if (wr_done) begin wr_ddr_req_i = 0; wr_done = 0; end
    else if (!wr_ddr_req_i && $urandom_range(3) == 0) begin
      wr_ddr_req_i = 1; wr_ddr_len_i = 8'($urandom_range(8)); wr_ddr_addr_i = AW'($urandom);
    end else if (wr_ddr_req_i && owner != O_WR && $urandom_range(31) == 0) wr_ddr_req_i = 0;
    if (rd_done) begin rd_ddr_req_i = 0; rd_done = 0; end
    else if (!rd_ddr_req_i && $urandom_range(3) == 0) begin
      rd_ddr_req_i = 1; rd_ddr_len_i = 8'($urandom_range(8)); rd_ddr_addr_i = AW'($urandom);
    end else if (rd_ddr_req_i && owner != O_RD && $urandom_range(31) == 0) rd_ddr_req_i = 0;
  endtask

  task automatic drain();
    wr_ddr_req_i = 0; rd_ddr_req_i = 0;
    strobe_pct = 100; fin_pct = 100; spur_pct = 0;
    for (int i = 0; i < 300 && owner != O_IDLE; i++) begin drive_mem(); step(); end
    chk("drain_bound", DW'(owner), DW'(O_IDLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    glog = 0; gn = 0; rd_fwd = 0;
    strobe_pct = 100; fin_pct = 100; spur_pct = 0;
    step();
    chk("rst_state", DW'({mem_wr_req_o, mem_rd_req_o, mem_len_o, mem_addr_o, wr_burst_cnt_o,
                          rd_burst_cnt_o, timeout_err_o, spurious_err_o}), '0);
    step();
    rst_n = 1;

    // read-only burst of 128 beats
    rd_ddr_req_i = 1; rd_ddr_len_i = 8'd128; rd_ddr_addr_i = 30'h400;
    chk("t1_pre_req", DW'(mem_rd_req_o), DW'(0));
    drive_mem(); step();
    chk("t1_req", DW'({mem_rd_req_o, mem_addr_o, mem_len_o}), DW'({1'b1, 30'h400, 8'd128}));
    rd_fwd = 0; rd_done = 0;
    for (int i = 0; i < 400 && !rd_done; i++) begin drive_mem(); step(); end
    chk("t1_done", DW'(rd_done), DW'(1));
    rd_ddr_req_i = 0;
    drive_mem(); step();
    chk("t1_valids", DW'(rd_fwd), DW'(128));
    chk("t1_cnt", DW'(rd_burst_cnt_o), DW'(1));
    drain();

    // both requesters held: write streak capped at 4
    wr_ddr_req_i = 1; wr_ddr_len_i = 1; wr_ddr_addr_i = 30'h100;
    rd_ddr_req_i = 1; rd_ddr_len_i = 1; rd_ddr_addr_i = 30'h200;
    glog = 0; gn = 0;
    for (int i = 0; i < 200 && gn < 10; i++) begin drive_mem(); step(); end
    chk("t2_order", DW'(glog[9:0]), DW'(10'b1111011110));
    drain();

    // stray read strobe during a write burst
    wr_ddr_req_i = 1; wr_ddr_len_i = 4; wr_ddr_addr_i = 30'h1234;
    strobe_pct = 0; fin_pct = 0;
    drive_mem(); step();
    mem_rd_data_valid_i = 1;
    #1;
    chk("t3_no_fwd", DW'(rd_ddr_data_valid_o), DW'(0));
    step();
    chk("t3_spur", DW'(spurious_err_o), DW'(1));
    for (int i = 0; i < 3; i++) begin drive_mem(); step(); end
    chk("t3_sticky", DW'(spurious_err_o), DW'(1));
    drain();

    // read burst that never finishes: watchdog fires at cycle 255 of the burst
    rd_ddr_req_i = 1; rd_ddr_len_i = 2; rd_ddr_addr_i = 30'h3000;
    strobe_pct = 100; fin_pct = 0;
    drive_mem(); step();
    rd_ddr_req_i = 0;
    for (int i = 0; i < 254; i++) begin drive_mem(); step(); end
    chk("t4_tout_early", DW'(timeout_err_o), DW'(0));
    drive_mem(); step();
    chk("t4_tout", DW'(timeout_err_o), DW'(1));
    fin_pct = 100; rd_done = 0;
    for (int i = 0; i < 10 && !rd_done; i++) begin drive_mem(); step(); end
    chk("t4_cnt", DW'(rd_burst_cnt_o), DW'(4));
    drain();
    chk("t4_tout_sticky", DW'(timeout_err_o), DW'(1));

    // asynchronous reset mid-burst
    wr_ddr_req_i = 1; wr_ddr_len_i = 8; wr_ddr_addr_i = 30'h55;
    strobe_pct = 50; fin_pct = 100;
    for (int i = 0; i < 4; i++) begin drive_mem(); step(); end
    mem_wr_data_req_i = 0; mem_wr_finish_i = 0; mem_rd_data_valid_i = 0; mem_rd_finish_i = 0;
    #2 rst_n = 0;
    #1;
    chk("t5_rst_out", DW'({mem_wr_req_o, mem_rd_req_o, mem_len_o, mem_addr_o, wr_burst_cnt_o, rd_burst_cnt_o,
                           timeout_err_o, spurious_err_o, wr_ddr_data_req_o, wr_ddr_finish_o,
                           rd_ddr_data_valid_o, rd_ddr_finish_o}), '0);
    model_reset();
    wr_ddr_req_i = 0;
    step(); step();
    rst_n = 1;
    rd_ddr_req_i = 1; rd_ddr_len_i = 1; rd_ddr_addr_i = 30'h80;
    drive_mem(); step();
    chk("t5_regrant", DW'({mem_rd_req_o, mem_addr_o}), DW'({1'b1, 30'h80}));
    drain();

    // finish and a new write request on the same cycle
    rd_ddr_req_i = 1; rd_ddr_len_i = 2; rd_ddr_addr_i = 30'h90;
    drive_mem(); step();
    rd_done = 0;
    for (int i = 0; i < 20 && !rd_done; i++) begin
      drive_mem();
      if (mem_rd_finish_i) begin wr_ddr_req_i = 1; wr_ddr_len_i = 3; wr_ddr_addr_i = 30'h2000; end
      step();
    end
    rd_ddr_req_i = 0;
    chk("t6_gap", DW'(mem_wr_req_o), DW'(0));
    drive_mem(); step();
    chk("t6_idle", DW'(mem_wr_req_o), DW'(0));
    drive_mem(); step();
    chk("t6_grant", DW'({mem_wr_req_o, mem_addr_o, mem_len_o}), DW'({1'b1, 30'h2000, 8'd3}));
    drain();
    chk("t6_cnts", DW'({wr_burst_cnt_o, rd_burst_cnt_o}), DW'({32'd1, 32'd2}));

    // randomized traffic with stray strobes
    wr_done = 0; rd_done = 0;
    strobe_pct = 60; fin_pct = 50; spur_pct = 3;
    for (int i = 0; i < 2500; i++) begin drive_req(); drive_mem(); step(); end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
